// File: rtl/jtpinpon_objline.sv
// jtpinpon_objline: sprite line renderer for the Pin Pon object path.
//
// For each draw request, one 16-pixel 2bpp sprite row is fetched from ROM.
// Every pixel is mapped through the 256x4 object palette PROM, and the
// opaque pixels are written into one half of a double line buffer. The
// other half is read out at pixel rate and erased right behind the read.
//
// Ports:
//   clk, rst           system clock, asynchronous active-high reset
//   pxl_cen, cen2      pixel enable, clk/2 enable (qualifies draw)
//   LHBL, hinit_x      active-low hblank, line start (buffer swap on rise)
//   hdump[8:0]         render column ([7:0] used)
//   draw / busy        request handshake; fields code/xpos/pal/hflip/vflip/ysub
//   prog_*             PROM load port (active even during reset)
//   rom_cs/addr/data/ok  SDRAM row fetch
//   pxl[3:0]           object pixel, 0 = transparent
//   debug_bus          reserved, unused
//
// Handshake: a request is accepted when draw=1 and cen2=1 while busy=0;
// busy rises on the next clk edge and falls once the last pixel has been
// written or the request was aborted by a buffer swap. draw is ignored while
// busy=1 and in the cycle of a swap.
module jtpinpon_objline #(
  parameter logic [7:0] HOFFSET = 8'd6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pxl_cen,
  input  logic        cen2,
  input  logic        LHBL,
  input  logic        hinit_x,
  input  logic [8:0]  hdump,
  input  logic        draw,
  output logic        busy,
  input  logic [7:0]  code,
  input  logic [7:0]  xpos,
  input  logic [4:0]  pal,
  input  logic        hflip,
  input  logic        vflip,
  input  logic [3:0]  ysub,
  input  logic [3:0]  prog_data,
  input  logic [7:0]  prog_addr,
  input  logic        prog_en,
  output logic        rom_cs,
  output logic [11:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        rom_ok,
  output logic [3:0]  pxl,
  input  logic [7:0]  debug_bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_DRAW} state_t;

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic        rom_cs_q, rom_cs_d;
  logic [11:0] rom_addr_q, rom_addr_d;
  logic        first_q, first_d;       // first FETCH cycle: rom_ok is stale
  logic [31:0] data_q, data_d;
  logic [4:0]  cnt_q, cnt_d;           // DRAW step 0..16
  logic [7:0]  xpos_q, xpos_d;
  logic [4:0]  pal_q, pal_d;
  logic        hflip_q, hflip_d;
  logic        wsel_q, wsel_d;         // half currently being drawn
  logic        hinit_last_q, hinit_last_d;
  logic        wv_q, wv_d;             // pipelined write valid
  logic [7:0]  wx_q, wx_d;
  logic [3:0]  wpix_q, wpix_d;
  logic [3:0]  pxl_q, pxl_d;

  logic [3:0]  prom [0:255];
  logic [3:0]  lbuf [0:511];           // {half, column}

  logic        swap;
  logic [3:0]  idx;
  logic [15:0] plane0, plane1;
  logic [1:0]  pix;
  logic [3:0]  prom_rd;
  logic [8:0]  rd_addr;

  logic unused_ok;
  assign unused_ok = ^{debug_bus, hdump[8]};

  assign swap    = hinit_x & ~hinit_last_q;
  assign plane0  = data_q[15:0];
  assign plane1  = data_q[31:16];
  // Screen pixel n uses bit 15-n (i.e. ~n) unless mirrored.
  assign idx     = hflip_q ? cnt_q[3:0] : ~cnt_q[3:0];
  assign pix     = {plane1[idx], plane0[idx]};
  assign prom_rd = prom[{1'b0, pal_q, pix}];
  assign rd_addr = {~wsel_q, hdump[7:0]};

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    rom_cs_d     = rom_cs_q;
    rom_addr_d   = rom_addr_q;
    first_d      = first_q;
    data_d       = data_q;
    cnt_d        = cnt_q;
    xpos_d       = xpos_q;
    pal_d        = pal_q;
    hflip_d      = hflip_q;
    wsel_d       = wsel_q ^ swap;
    hinit_last_d = hinit_x;
    pxl_d        = pxl_q;

    case (state_q)
      ST_IDLE: begin
        if (draw && cen2 && !swap) begin
          rom_addr_d = {code, ysub ^ {4{vflip}}};
          xpos_d     = xpos;
          pal_d      = pal;
          hflip_d    = hflip;
          busy_d     = 1'b1;
          rom_cs_d   = 1'b1;
          first_d    = 1'b1;
          state_d    = ST_FETCH;
        end
      end
      ST_FETCH: begin
        first_d = 1'b0;
        if (!first_q && rom_ok) begin
          data_d   = rom_data;
          rom_cs_d = 1'b0;
          cnt_d    = 5'd0;
          state_d  = ST_DRAW;
        end
      end
      ST_DRAW: begin
        cnt_d = cnt_q + 5'd1;
        // Step 16 only flushes the PROM pipeline's last pixel.
        if (cnt_q == 5'd16) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A line start abandons any request in flight.
    if (swap && state_q != ST_IDLE) begin
      state_d  = ST_IDLE;
      busy_d   = 1'b0;
      rom_cs_d = 1'b0;
    end

    wv_d   = (state_q == ST_DRAW) && !cnt_q[4] && !swap;
    wx_d   = xpos_q + HOFFSET + {4'd0, cnt_q[3:0]};
    wpix_d = prom_rd;

    if (pxl_cen) pxl_d = LHBL ? lbuf[rd_addr] : 4'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      rom_cs_q     <= 1'b0;
      rom_addr_q   <= 12'd0;
      first_q      <= 1'b0;
      data_q       <= 32'd0;
      cnt_q        <= 5'd0;
      xpos_q       <= 8'd0;
      pal_q        <= 5'd0;
      hflip_q      <= 1'b0;
      wsel_q       <= 1'b0;
      hinit_last_q <= 1'b0;
      wv_q         <= 1'b0;
      wx_q         <= 8'd0;
      wpix_q       <= 4'd0;
      pxl_q        <= 4'd0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      rom_cs_q     <= rom_cs_d;
      rom_addr_q   <= rom_addr_d;
      first_q      <= first_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
      xpos_q       <= xpos_d;
      pal_q        <= pal_d;
      hflip_q      <= hflip_d;
      wsel_q       <= wsel_d;
      hinit_last_q <= hinit_last_d;
      wv_q         <= wv_d;
      wx_q         <= wx_d;
      wpix_q       <= wpix_d;
      pxl_q        <= pxl_d;
    end
  end

  always_ff @(posedge clk) begin
    if (prog_en) prom[prog_addr] <= prog_data;
  end

  // Draw side and readout side always address opposite halves.
  // The pending pixel is dropped on a swap so an aborted sprite
  // never spills into the line being shown.
  always_ff @(posedge clk) begin
    if (wv_q && wpix_q != 4'd0 && !swap) lbuf[{wsel_q, wx_q}] <= wpix_q;
    if (pxl_cen && LHBL) lbuf[rd_addr] <= 4'd0;
  end

  assign busy     = busy_q;
  assign rom_cs   = rom_cs_q;
  assign rom_addr = rom_addr_q;
  assign pxl      = pxl_q;

endmodule

// File: tb/tb_jtpinpon_objline.sv
// Bench for jtpinpon_objline: directed requests, a model of the PROM and of
// both line buffer halves, and full-line readouts compared column by column.
module tb_jtpinpon_objline;

  localparam logic [7:0] HOFF = 8'd6;

  logic        clk, rst, pxl_cen, cen2, LHBL, hinit_x, draw, busy;
  logic [8:0]  hdump;
  logic [7:0]  code, xpos;
  logic [4:0]  pal;
  logic        hflip, vflip;
  logic [3:0]  ysub, prog_data, pxl;
  logic [7:0]  prog_addr, debug_bus;
  logic        prog_en, rom_cs, rom_ok;
  logic [11:0] rom_addr;
  logic [31:0] rom_data;

  jtpinpon_objline #(.HOFFSET(HOFF)) dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .cen2(cen2), .LHBL(LHBL),
    .hinit_x(hinit_x), .hdump(hdump), .draw(draw), .busy(busy),
    .code(code), .xpos(xpos), .pal(pal), .hflip(hflip), .vflip(vflip),
    .ysub(ysub), .prog_data(prog_data), .prog_addr(prog_addr),
    .prog_en(prog_en), .rom_cs(rom_cs), .rom_addr(rom_addr),
    .rom_data(rom_data), .rom_ok(rom_ok), .pxl(pxl), .debug_bus(debug_bus)
  );

  int checks = 0;
  int failures = 0;
  logic [3:0] exp_q[$];
  logic [3:0] prom_m [256];
  logic [3:0] mb [2][256];
  logic       wsel_m;
  logic [7:0]  r_xpos;
  logic [4:0]  r_pal;
  logic        r_hflip;
  logic [31:0] r_word;

  // clock / reset block
  initial begin
    clk  = 1'b0;
    cen2 = 1'b0;
  end
  always #5 clk = ~clk;
  always @(posedge clk) cen2 <= ~cen2;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic swap_lines;
    hinit_x = 1'b1;
    step;
    step;
    hinit_x = 1'b0;
    step;
    wsel_m = ~wsel_m;
  endtask

  task automatic wait_cen2;
    int guard;
    guard = 0;
    while (cen2 !== 1'b1 && guard < 4) begin
      step;
      guard++;
    end
  endtask

  task automatic start_req(input logic [7:0] c, input logic [7:0] x, input logic [4:0] p,
                           input logic hf, input logic vf, input logic [3:0] ys,
                           input logic [31:0] word);
    logic [11:0] ea;
    wait_cen2;
    code = c; xpos = x; pal = p; hflip = hf; vflip = vf; ysub = ys;
    rom_data = word; rom_ok = 1'b0; draw = 1'b1;
    r_xpos = x; r_pal = p; r_hflip = hf; r_word = word;
    ea = {c, ys ^ {4{vf}}};
    step;
    draw = 1'b0;
    check("busy_rise", {31'd0, busy}, 32'd1);
    check("rom_cs_rise", {31'd0, rom_cs}, 32'd1);
    check("rom_addr", {20'd0, rom_addr}, {20'd0, ea});
  endtask

  task automatic model_draw;
    logic [3:0] idx;
    logic [1:0] pix;
    logic [3:0] v;
    logic [7:0] col;
    for (int n = 0; n < 16; n++) begin
      idx = r_hflip ? n[3:0] : 4'(15 - n);
      pix = {r_word[16 + int'(idx)], r_word[int'(idx)]};
      v   = prom_m[{1'b0, r_pal, pix}];
      col = r_xpos + HOFF + n[7:0];
      if (v != 4'd0) mb[wsel_m][col] = v;
    end
  endtask

  task automatic finish_req(input int w);
    int n;
    if (w == 0) begin
      rom_ok = 1'b1;
      step;
      check("first_fetch_ignored", {31'd0, rom_cs}, 32'd1);
    end else begin
      for (int i = 0; i < w; i++) begin
        step;
        check("wait_rom_cs", {31'd0, rom_cs}, 32'd1);
        check("wait_busy", {31'd0, busy}, 32'd1);
      end
      rom_ok = 1'b1;
    end
    step;
    check("capture_rom_cs", {31'd0, rom_cs}, 32'd0);
    check("capture_busy", {31'd0, busy}, 32'd1);
    rom_ok = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      step;
      n++;
    end
    check("draw_len", n, 32'd17);
    model_draw;
  endtask

  task automatic read_line(input bit do_check);
    logic rsel;
    rsel = ~wsel_m;
    hdump = 9'd16; LHBL = 1'b0; pxl_cen = 1'b1;
    step;
    pxl_cen = 1'b0;
    if (do_check) check("blank_pxl", {28'd0, pxl}, 32'd0);
    for (int c = 0; c < 256; c++) begin
      hdump = c[8:0]; LHBL = 1'b1; pxl_cen = 1'b1;
      if (do_check) exp_q.push_back(mb[rsel][c]);
      mb[rsel][c] = 4'd0;
      step;
      pxl_cen = 1'b0; LHBL = 1'b0;
      if (do_check) check($sformatf("pxl_col%0d", c), {28'd0, pxl}, {28'd0, exp_q.pop_front()});
    end
  endtask

  initial begin
    rst = 1'b1; pxl_cen = 1'b0; LHBL = 1'b0; hinit_x = 1'b0; hdump = 9'd0;
    draw = 1'b0; code = 8'd0; xpos = 8'd0; pal = 5'd0; hflip = 1'b0; vflip = 1'b0;
    ysub = 4'd0; prog_data = 4'd0; prog_addr = 8'd0; prog_en = 1'b0;
    rom_data = 32'd0; rom_ok = 1'b0; debug_bus = 8'd0; wsel_m = 1'b0;
    for (int h = 0; h < 2; h++)
      for (int c = 0; c < 256; c++) mb[h][c] = 4'd0;
    for (int a = 0; a < 256; a++) begin
      if (a[6:2] == 5'd3) prom_m[a] = 4'(a[1:0] + 1);
      else if (a[1:0] == 2'd0) prom_m[a] = 4'd0;
      else prom_m[a] = 4'($urandom_range(1, 15));
    end

    // PROM loads while reset is still asserted
    step;
    for (int a = 0; a < 256; a++) begin
      prog_addr = a[7:0]; prog_data = prom_m[a]; prog_en = 1'b1;
      step;
    end
    prog_en = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rom_cs", {31'd0, rom_cs}, 32'd0);
    check("rst_rom_addr", {20'd0, rom_addr}, 32'd0);
    check("rst_pxl", {28'd0, pxl}, 32'd0);
    rst = 1'b0;
    step;

    // Flush whatever the line buffer RAM powered up with
    swap_lines; read_line(1'b0);
    swap_lines; read_line(1'b0);

    // Basic draw, hflip single pixel, overlapping vflip sprite with SDRAM wait
    start_req(8'h05, 8'd10, 5'd3, 1'b0, 1'b0, 4'd2, 32'hFFFF_0000);
    finish_req(0);
    start_req(8'h33, 8'd20, 5'd4, 1'b1, 1'b0, 4'd7, 32'h0000_8000);
    finish_req(0);
    start_req(8'h21, 8'd14, 5'd4, 1'b0, 1'b1, 4'd2, 32'h0F0F_00FF);
    finish_req(3);
    swap_lines;
    read_line(1'b1);

    // Wrap-around at the right edge with a long SDRAM wait
    start_req(8'h7A, 8'd252, 5'd5, 1'b0, 1'b0, 4'd9, $urandom);
    finish_req(10);
    swap_lines;
    read_line(1'b1);

    // Abort mid-draw by a line start
    start_req(8'h10, 8'd40, 5'd4, 1'b0, 1'b0, 4'd1, 32'h0000_0000);
    rom_ok = 1'b1;
    repeat (8) step;
    rom_ok = 1'b0;
    hinit_x = 1'b1;
    step;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_rom_cs", {31'd0, rom_cs}, 32'd0);
    step;
    hinit_x = 1'b0;
    step;
    wsel_m = ~wsel_m;

    // draw coinciding with a swap is dropped
    wait_cen2;
    hinit_x = 1'b1; draw = 1'b1;
    step;
    draw = 1'b0;
    check("swap_draw_busy", {31'd0, busy}, 32'd0);
    step;
    check("swap_draw_busy2", {31'd0, busy}, 32'd0);
    hinit_x = 1'b0;
    step;
    wsel_m = ~wsel_m;

    // Same half as the wrap line: erased by its readout
    read_line(1'b1);

    // Asynchronous reset in the middle of a fetch
    start_req(8'h44, 8'd0, 5'd3, 1'b0, 1'b0, 4'd0, 32'h1234_5678);
    step;
    rst = 1'b1;
    #1;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_rom_cs", {31'd0, rom_cs}, 32'd0);
    step;
    rst = 1'b0;
    step;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtpinpon_objline.md
# jtpinpon_objline

Sprite line renderer for the Pin Pon object path. It sits directly downstream of the object table scanner and accepts one draw request per visible sprite. For each request it fetches one 16-pixel, 2bpp row from the sprite ROM, maps every pixel through the 256×4 object palette PROM, and writes the opaque pixels into a double line buffer. The other half of the buffer is read out at pixel rate to feed the colour mixer.

## Interface
Parameters:
- HOFFSET, 8'd6, horizontal offset added to xpos when writing into the line buffer.

Ports:
- clk  in  1  48 MHz system clock.
- rst  in  1  asynchronous, active-high reset.
- pxl_cen  in  1  pixel clock enable.
- cen2  in  1  clk/2 enable; also qualifies `draw` sampling.
- LHBL  in  1  active-low horizontal blank.
- hinit_x  in  1  line start; high for at least one cen2 period.
- hdump  in  9  horizontal render counter; only bits [7:0] are used.
- draw  in  1  draw request, sampled only when cen2=1.
- busy  out  1  high while a request is in progress.
- code  in  8  sprite code.
- xpos  in  8  sprite left edge.
- pal  in  5  palette select.
- hflip  in  1  horizontal mirror.
- vflip  in  1  vertical mirror.
- ysub  in  4  row within the sprite, 0..15.
- prog_data  in  4  PROM load data.
- prog_addr  in  8  PROM load address.
- prog_en  in  1  PROM write strobe.
- rom_cs  out  1  SDRAM request.
- rom_addr  out  12  SDRAM word address.
- rom_data  in  32  SDRAM data.
- rom_ok  in  1  SDRAM data valid.
- pxl  out  4  object pixel; 0 means transparent.
- debug_bus  in  8  reserved; no effect on the output.

## Operation
- **Reset values:** busy=0, rom_cs=0, rom_addr=0, pxl=0, state IDLE, write-buffer select=0. RAM and PROM contents are not reset.
- **PROM:** written whenever prog_en=1, regardless of rst. Lookup address = {1'b0, pal, pix[1:0]}.
- **ROM word:** rom_addr = {code, ysub ^ {4{vflip}}}.
  - Plane 0 = rom_data[15:0], plane 1 = rom_data[31:16].
  - Screen pixel n (n=0..15, left to right) = {plane1[15-n], plane0[15-n]}.
  - With hflip=1, bit index n is used instead of 15-n.
- **FSM:**
  - IDLE: when draw=1 and cen2=1, latch all request fields, set busy=1, go to FETCH.
  - FETCH: rom_cs=1. rom_ok is ignored on the first FETCH cycle. On a later cycle with rom_ok=1, latch rom_data, drop rom_cs and go to DRAW.
  - DRAW: one pixel per clk, n=0..15, through a 1-stage PROM pipeline. Write target = (xpos + HOFFSET + n) mod 256 in the write buffer. A PROM output of 0 does not write. After the last write, return to IDLE with busy=0.
  - draw while busy=1 is ignored.
- **Buffer swap:** on the rising edge of hinit_x, invert the write-buffer select; the read buffer is the other half.
  - A swap during FETCH or DRAW aborts the request: next cycle busy=0, rom_cs=0, state IDLE.
  - If draw is asserted in the same cycle as the swap, the swap wins and draw is ignored.
- **Readout:** on each pxl_cen with LHBL=1, read the read buffer at hdump[7:0], present that value on pxl, then write 0 to the same location before the next pxl_cen.
  - With LHBL=0, pxl becomes 0 and no erase occurs.
  - Write-side and read-side accesses always target different halves, so there is no port conflict.
- **Wrap-around:** x addresses wrap modulo 256, so a sprite with xpos near 255 continues at column 0.

## Timing
- busy rises on the clk edge after draw is sampled. The upstream scanner waits one cen2 period before polling busy.
- Minimum request duration with rom_ok already high: 1 latch + 2 FETCH + 17 DRAW = 20 clk, then busy=0. Each extra cycle of SDRAM wait adds 1 clk.
- Sequential requests with overlapping x: the later request overwrites earlier opaque pixels; transparent pixels preserve earlier ones.
- pxl latency: the pixel at hdump=h appears at the pxl_cen following the one that presented h, i.e. one pixel of latency. Downstream alignment uses HOFFSET.
- Asserting rst mid-request: busy and rom_cs clear immediately.

## Test plan
- **Basic draw:** PROM[{0,pal=3,pix}] = pix+1; ROM row = 32'hFFFF_0000; code=5, ysub=2, xpos=10, no flip → rom_addr=12'h052; next line, buffer columns 16..31 read 4'h3 with HOFFSET=6.
- **Flips:** plane0=16'h8000, plane1=0, hflip=1 → only column xpos+HOFFSET+15 is written, with pix=1. vflip=1, ysub=2 → rom_addr low nibble = 4'hD.
- **Transparency:** PROM entry for pix=0 is 0 → a second sprite overlapping the first leaves the first sprite's pixels intact where pix=0.
- **Wrap:** xpos=252 → pixels land at columns 2..17 (mod 256).
- **SDRAM wait:** hold rom_ok=0 for 10 cycles → rom_cs stays high and busy stays high; busy falls 17 clk after the capture.
- **Abort and clear:** hinit_x mid-DRAW → busy=0 and rom_cs=0 next clk. The line after readout reads all zeros, because the buffer is erased after read.
